// File: rtl/apb_controller.sv
// ---------------------------------------------------------------------------
// apb_controller
//
// Bridge-side APB2 master FSM. It accepts one registered AHB transfer at a
// time and runs the SETUP/ACCESS sequence toward the APB interface stage.
// Read data returned on PRDATA is captured into HRDATA when the ACCESS phase
// completes. HREADYOUT is low while a transfer is in flight, which stalls the
// AHB side.
//
// Parameters
//   ACCESS_WAIT  extra ACCESS cycles beyond the first (0..15)
//
// Ports
//   Hclk        in   1   bridge clock, rising edge
//   Hreset      in   1   synchronous, active-high reset
//   valid       in   1   AHB slave i/f presents a valid transfer
//   HADDR_reg   in  32   registered transfer address
//   HWRITE_reg  in   1   registered direction (1 = write)
//   HWDATA      in  32   AHB write data, one cycle after valid for writes
//   TEMPSEL     in   3   one-hot slave decode of HADDR_reg
//   PRDATA      in  32   APB read data
//   PENABLE     out  1   APB enable (ACCESS phase)
//   PWRITE      out  1   APB direction
//   PSEL        out  3   APB one-hot slave select
//   PADDR       out 32   APB address
//   PWDATA      out 32   APB write data
//   HREADYOUT   out  1   1 = bridge idle, can accept a transfer
//   HRDATA      out 32   last captured read data
// ---------------------------------------------------------------------------
module apb_controller #(
  parameter int unsigned ACCESS_WAIT = 0
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        valid,
  input  logic [31:0] HADDR_reg,
  input  logic        HWRITE_reg,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  TEMPSEL,
  input  logic [31:0] PRDATA,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [2:0]  PSEL,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WWAIT  = 2'd1,
    SETUP  = 2'd2,
    ACCESS = 2'd3
  } state_t;

  state_t      state, next_state;
  logic [3:0]  wait_cnt, wait_cnt_d;
  logic [2:0]  sel_q, sel_q_d;

  // Next values of the registered outputs, computed by the output process.
  logic        penable_d;
  logic        pwrite_d;
  logic [2:0]  psel_d;
  logic [31:0] paddr_d;
  logic [31:0] pwdata_d;
  logic        hreadyout_d;
  logic [31:0] hrdata_d;

  logic accept;

  // A transfer is taken only from IDLE and only when it decodes to a slave;
  // decode misses are silently dropped.
  assign accept = (state == IDLE) && valid && (TEMPSEL != 3'b000);

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      sel_q     <= 3'b000;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PSEL      <= 3'b000;
      PADDR     <= 32'd0;
      PWDATA    <= 32'd0;
      HREADYOUT <= 1'b1;
      HRDATA    <= 32'd0;
    end else begin
      state     <= next_state;
      wait_cnt  <= wait_cnt_d;
      sel_q     <= sel_q_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PSEL      <= psel_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      HREADYOUT <= hreadyout_d;
      HRDATA    <= hrdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = HWRITE_reg ? WWAIT : SETUP;
      WWAIT:   next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) next_state = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: next values for the registered outputs
  // -------------------------------------------------------------------------
  always_comb begin
    wait_cnt_d  = wait_cnt;
    sel_q_d     = sel_q;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    psel_d      = PSEL;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    hreadyout_d = HREADYOUT;
    hrdata_d    = HRDATA;

    unique case (state)
      IDLE: begin
        if (accept) begin
          sel_q_d     = TEMPSEL;
          paddr_d     = HADDR_reg;
          pwrite_d    = HWRITE_reg;
          hreadyout_d = 1'b0;
          // Reads go straight to SETUP, so PSEL must be up on the next
          // cycle; writes raise it after the WWAIT data-capture cycle.
          if (!HWRITE_reg) psel_d = TEMPSEL;
        end
      end

      WWAIT: begin
        // AHB write data arrives one cycle after the address phase.
        pwdata_d = HWDATA;
        psel_d   = sel_q;
      end

      SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = 4'(ACCESS_WAIT);
      end

      ACCESS: begin
        if (wait_cnt != 4'd0) begin
          wait_cnt_d = wait_cnt - 4'd1;
        end else begin
          psel_d      = 3'b000;
          penable_d   = 1'b0;
          hreadyout_d = 1'b1;
          // PRDATA is valid on the final ACCESS edge.
          if (!PWRITE) hrdata_d = PRDATA;
        end
      end
    endcase
  end

endmodule
